// File: rtl/xls_fifo_pkg.sv
// rtl/xls_fifo_pkg.sv - sizing helpers shared by the ring FIFO and its storage
package xls_fifo_pkg;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/xls_fifo_mem.sv
// rtl/xls_fifo_mem.sv - 1-write/1-read storage array for the ring FIFO, no reset
module xls_fifo_mem
  import xls_fifo_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 32
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [addr_width(Depth)-1:0] wr_addr,
  input  logic [Width-1:0]           wr_data,
  input  logic [addr_width(Depth)-1:0] rd_addr,
  output logic [Width-1:0]           rd_data
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/xls_ring_fifo.sv
// rtl/xls_ring_fifo.sv - ring-buffer FIFO with optional bypass and registered push/pop sides
module xls_ring_fifo
  import xls_fifo_pkg::*;
#(
  parameter int Width               = 32,
  parameter int Depth               = 32,
  parameter int EnableBypass        = 0,
  parameter int RegisterPushOutputs = 1,
  parameter int RegisterPopOutputs  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [Width-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [Width-1:0] pop_data,
  input  logic             pop_ready
);

  localparam int AW = addr_width(Depth);
  localparam int CW = count_width(Depth);

  if ((EnableBypass != 0) && (RegisterPopOutputs != 0)) begin : g_bad_cfg
    $error("xls_ring_fifo: EnableBypass requires RegisterPopOutputs=0");
  end

  logic [CW-1:0]    count_q, count_d, remain;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
  logic             pop_valid_q, pop_valid_d;
  logic [Width-1:0] pop_data_q, pop_data_d, mem_rdata;
  logic             empty, full, bypass, push_fire, pop_fire, store, pop_mem;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(Depth));
    bypass     = (EnableBypass != 0) && empty;
    push_ready = !rst && (!full || ((RegisterPushOutputs == 0) && pop_ready));
    if (RegisterPopOutputs != 0) begin
      pop_valid = !rst && pop_valid_q;
    end else begin
      pop_valid = !rst && (!empty || (bypass && push_valid));
    end
    push_fire = push_valid && push_ready;
    pop_fire  = pop_valid && pop_ready;
    // A bypassed entry goes straight to the consumer and never occupies storage.
    store     = push_fire && !(bypass && pop_fire);
    pop_mem   = pop_fire && !empty;
    remain    = pop_mem ? count_q - CW'(1) : count_q;
    count_d   = store ? remain + CW'(1) : remain;
    wr_ptr_d  = store ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop_mem ? next_ptr(rd_ptr_q) : rd_ptr_q;
    pop_valid_d = (count_d != '0);
  end

  // The registered pop side prefetches the head that will exist after this edge.
  assign rd_addr = (RegisterPopOutputs != 0) ? rd_ptr_d : rd_ptr_q;

  always_comb begin
    pop_data_d = pop_data_q;
    if (count_d != '0) begin
      pop_data_d = (remain == '0) ? push_data : mem_rdata;
    end
    if (RegisterPopOutputs != 0) begin
      pop_data = pop_data_q;
    end else begin
      pop_data = bypass ? push_data : mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_valid_q <= pop_valid_d;
    end
    pop_data_q <= pop_data_d;
  end

  xls_fifo_mem #(
    .Width (Width),
    .Depth (Depth)
  ) u_mem (
    .clk     (clk),
    .wr_en   (store),
    .wr_addr (wr_ptr_q),
    .wr_data (push_data),
    .rd_addr (rd_addr),
    .rd_data (mem_rdata)
  );

endmodule

// File: tb/tb_xls_ring_fifo.sv
// tb/tb_xls_ring_fifo.sv - directed and scoreboarded checks across several FIFO configurations
module tb_xls_ring_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       push_valid [5];
  logic [7:0] push_data  [5];
  logic       push_ready [5];
  logic       pop_valid  [5];
  logic [7:0] pop_data   [5];
  logic       pop_ready  [5];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  // 0: defaults Depth 4; 1: Depth 3; 2: Depth 4 comb push/pop; 3: bypass Depth 2; 4: Depth 5
  xls_ring_fifo #(.Width(8), .Depth(4)) u_a (
    .clk(clk), .rst(rst), .push_valid(push_valid[0]), .push_data(push_data[0]), .push_ready(push_ready[0]),
    .pop_valid(pop_valid[0]), .pop_data(pop_data[0]), .pop_ready(pop_ready[0]));
  xls_ring_fifo #(.Width(8), .Depth(3)) u_b (
    .clk(clk), .rst(rst), .push_valid(push_valid[1]), .push_data(push_data[1]), .push_ready(push_ready[1]),
    .pop_valid(pop_valid[1]), .pop_data(pop_data[1]), .pop_ready(pop_ready[1]));
  xls_ring_fifo #(.Width(8), .Depth(4), .RegisterPushOutputs(0), .RegisterPopOutputs(0)) u_c (
    .clk(clk), .rst(rst), .push_valid(push_valid[2]), .push_data(push_data[2]), .push_ready(push_ready[2]),
    .pop_valid(pop_valid[2]), .pop_data(pop_data[2]), .pop_ready(pop_ready[2]));
  xls_ring_fifo #(.Width(8), .Depth(2), .EnableBypass(1), .RegisterPopOutputs(0)) u_d (
    .clk(clk), .rst(rst), .push_valid(push_valid[3]), .push_data(push_data[3]), .push_ready(push_ready[3]),
    .pop_valid(pop_valid[3]), .pop_data(pop_data[3]), .pop_ready(pop_ready[3]));
  xls_ring_fifo #(.Width(8), .Depth(5)) u_e (
    .clk(clk), .rst(rst), .push_valid(push_valid[4]), .push_data(push_data[4]), .push_ready(push_ready[4]),
    .pop_valid(pop_valid[4]), .pop_data(pop_data[4]), .pop_ready(pop_ready[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_c [4];
  logic [7:0] sb [$];
  int         sent;
  int         cycles;

  initial begin
    for (int k = 0; k < 5; k++) begin
      push_valid[k] = 1'b0;
      push_data[k]  = 8'h00;
      pop_ready[k]  = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_a_push_ready", push_ready[0], 1);
    check("rst_a_pop_valid", pop_valid[0], 0);
    check("rst_c_pop_valid", pop_valid[2], 0);
    check("rst_d_push_ready", push_ready[3], 1);

    // Fill Depth 4 with no pops, then drain in order.
    for (int i = 0; i < 4; i++) begin
      push_valid[0] = 1'b1;
      push_data[0]  = 8'(8'hA1 + i);
      #1;
      check("a_fill_ready", push_ready[0], 1);
      check("a_fill_pop_valid", pop_valid[0], 32'(i > 0));
      tick();
    end
    push_data[0] = 8'hA5;
    #1;
    check("a_full_ready", push_ready[0], 0);
    check("a_head", pop_data[0], 32'hA1);
    tick();
    check("a_full_hold", push_ready[0], 0);
    check("a_stable", pop_data[0], 32'hA1);
    push_valid[0] = 1'b0;
    pop_ready[0]  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("a_drain_valid", pop_valid[0], 1);
      check("a_drain_data", pop_data[0], 32'(8'hA1 + i));
      tick();
    end
    check("a_empty", pop_valid[0], 0);
    pop_ready[0] = 1'b0;

    // Depth 3 streaming: occupancy stays at one, pointers wrap several times.
    pop_ready[1] = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      push_valid[1] = (t < 10);
      push_data[1]  = 8'(t);
      #1;
      check("b_pop_valid", pop_valid[1], 32'(t > 0));
      if (t > 0) check("b_pop_data", pop_data[1], 32'(t - 1));
      check("b_push_ready", push_ready[1], 1);
      tick();
    end
    check("b_empty", pop_valid[1], 0);
    pop_ready[1] = 1'b0;

    // Full with combinational push_ready: simultaneous push and pop keeps count at 4.
    for (int i = 0; i < 4; i++) begin
      push_valid[2] = 1'b1;
      push_data[2]  = 8'(8'h10 + i);
      tick();
    end
    push_data[2] = 8'h55;
    #1;
    check("c_full_no_pop", push_ready[2], 0);
    pop_ready[2] = 1'b1;
    #1;
    check("c_full_with_pop", push_ready[2], 1);
    check("c_head", pop_data[2], 32'h10);
    tick();
    pop_ready[2] = 1'b0;
    #1;
    check("c_still_full", push_ready[2], 0);
    check("c_new_head", pop_data[2], 32'h11);
    push_valid[2] = 1'b0;
    pop_ready[2]  = 1'b1;
    exp_c[0] = 8'h11; exp_c[1] = 8'h12; exp_c[2] = 8'h13; exp_c[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("c_drain_valid", pop_valid[2], 1);
      check("c_drain_data", pop_data[2], 32'(exp_c[i]));
      tick();
    end
    check("c_empty", pop_valid[2], 0);
    check("c_empty_ready", push_ready[2], 1);
    tick();
    check("c_empty_hold", pop_valid[2], 0);
    pop_ready[2] = 1'b0;

    // Bypass: empty push forwarded in the same cycle, not stored.
    push_valid[3] = 1'b1;
    push_data[3]  = 8'h77;
    pop_ready[3]  = 1'b1;
    #1;
    check("d_bypass_valid", pop_valid[3], 1);
    check("d_bypass_data", pop_data[3], 32'h77);
    check("d_bypass_ready", push_ready[3], 1);
    tick();
    push_valid[3] = 1'b0;
    #1;
    check("d_not_stored", pop_valid[3], 0);
    push_valid[3] = 1'b1;
    push_data[3]  = 8'h88;
    pop_ready[3]  = 1'b0;
    #1;
    check("d_fwd_valid", pop_valid[3], 1);
    check("d_fwd_data", pop_data[3], 32'h88);
    tick();
    push_valid[3] = 1'b0;
    pop_ready[3]  = 1'b1;
    #1;
    check("d_stored_valid", pop_valid[3], 1);
    check("d_stored_data", pop_data[3], 32'h88);
    tick();
    check("d_drained", pop_valid[3], 0);
    pop_ready[3] = 1'b0;

    // Reset mid-stream discards held entries.
    push_valid[0] = 1'b1;
    push_data[0]  = 8'hB1;
    tick();
    push_data[0] = 8'hB2;
    tick();
    push_valid[0] = 1'b0;
    pop_ready[0]  = 1'b1;
    #1;
    check("r_head", pop_data[0], 32'hB1);
    tick();
    rst           = 1'b1;
    push_valid[0] = 1'b1;
    push_data[0]  = 8'hC1;
    #1;
    check("r_in_rst_ready", push_ready[0], 0);
    check("r_in_rst_valid", pop_valid[0], 0);
    tick();
    rst           = 1'b0;
    push_valid[0] = 1'b0;
    #1;
    check("r_after_valid", pop_valid[0], 0);
    check("r_after_ready", push_ready[0], 1);
    tick();
    check("r_no_old", pop_valid[0], 0);
    push_valid[0] = 1'b1;
    push_data[0]  = 8'hD1;
    tick();
    push_valid[0] = 1'b0;
    #1;
    check("r_new_valid", pop_valid[0], 1);
    check("r_new_data", pop_data[0], 32'hD1);
    tick();
    check("r_new_drained", pop_valid[0], 0);
    pop_ready[0] = 1'b0;

    // Random stalls against a queue scoreboard, with one reset pulse mid-run.
    sent   = 0;
    cycles = 0;
    while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
      cycles++;
      rst           = (cycles == 400);
      push_valid[4] = (sent < 1000) && ($urandom_range(0, 3) != 0);
      push_data[4]  = 8'($urandom);
      pop_ready[4]  = ($urandom_range(0, 2) != 0);
      #1;
      if (rst) begin
        check("e_rst_ready", push_ready[4], 0);
        check("e_rst_valid", pop_valid[4], 0);
        sb.delete();
      end else begin
        check("e_pop_valid", pop_valid[4], 32'(sb.size() != 0));
        check("e_push_ready", push_ready[4], 32'(sb.size() != 5));
        if (pop_valid[4] && pop_ready[4] && sb.size() != 0) begin
          check("e_data", pop_data[4], 32'(sb[0]));
          void'(sb.pop_front());
        end
        if (push_valid[4] && push_ready[4]) begin
          sb.push_back(push_data[4]);
          sent++;
        end
      end
      tick();
    end
    rst           = 1'b0;
    push_valid[4] = 1'b0;
    pop_ready[4]  = 1'b0;
    check("e_done", 32'((sent == 1000) && (sb.size() == 0)), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
